// File: rtl/toggle_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : toggle_event_decoder
// Description : Receive side of a toggle-encoded event line. Recovers event
//               pulses, queues them behind valid/ready and counts them.
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tog_in,
    input  logic              evt_ready,
    input  logic              clr_cnt,
    output logic              level_out,
    output logic              evt_pulse,
    output logic              evt_valid,
    output logic [PEND_W-1:0] pend_cnt,
    output logic [CNT_W-1:0]  total_cnt,
    output logic              overflow,
    output logic              armed
);

    localparam int                 c_ARM_W    = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [c_ARM_W-1:0] c_ARM_LAST = c_ARM_W'(SYNC_STAGES);
    localparam logic [PEND_W-1:0]  c_PEND_MAX = '1;

    typedef enum logic [0:0] {
        ST_ARM = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_ARM_W-1:0]   r_arm_cnt;
    logic                 r_prev;
    logic                 r_level;
    logic                 r_pulse;
    logic                 r_ovf;
    logic [PEND_W-1:0]    r_pend;
    logic [CNT_W-1:0]     r_total;
    logic                 w_s;
    logic                 w_event;
    logic                 w_accept;
    logic                 w_pend_full;

    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_event     = (r_state == ST_RUN) && (w_s != r_prev);
    assign w_accept    = evt_valid & evt_ready;
    assign w_pend_full = (r_pend == c_PEND_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ARM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ARM lets the synchroniser and prev register settle on the line level
    // present at reset release so it is not mistaken for an event.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ARM:  if (r_arm_cnt == c_ARM_LAST) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_arm_cnt <= '0;
            r_prev    <= 1'b0;
            r_level   <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], tog_in};
            r_prev  <= w_s;
            r_level <= w_s;
            r_pulse <= w_event;
            if (r_state == ST_ARM) begin
                r_arm_cnt <= r_arm_cnt + 1'b1;
            end
        end
    end

    // A same-cycle accept cancels the new event, so a full queue only drops
    // when nothing leaves it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_total <= '0;
        end else begin
            if (w_event && !w_accept) begin
                if (!w_pend_full) begin
                    r_pend <= r_pend + 1'b1;
                end
            end else if (!w_event && w_accept) begin
                r_pend <= r_pend - 1'b1;
            end

            if (clr_cnt) begin
                r_ovf   <= 1'b0;
                r_total <= '0;
            end else begin
                if (w_event && !w_accept && w_pend_full) begin
                    r_ovf <= 1'b1;
                end
                if (w_event) begin
                    r_total <= r_total + 1'b1;
                end
            end
        end
    end

    assign level_out = r_level;
    assign evt_pulse = r_pulse;
    assign evt_valid = (r_pend != '0);
    assign pend_cnt  = r_pend;
    assign total_cnt = r_total;
    assign overflow  = r_ovf;
    assign armed     = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_toggle_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_toggle_event_decoder
// Description : Self-checking bench for toggle_event_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_event_decoder;

    localparam int c_S    = 2;
    localparam int c_PW   = 4;
    localparam int c_CW   = 8;
    localparam int c_PMAX = 15;
    localparam int c_CMOD = 256;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            tog_in    = 1'b0;
    logic            evt_ready = 1'b0;
    logic            clr_cnt   = 1'b0;
    logic            level_out;
    logic            evt_pulse;
    logic            evt_valid;
    logic [c_PW-1:0] pend_cnt;
    logic [c_CW-1:0] total_cnt;
    logic            overflow;
    logic            armed;
    logic [16:0]     dut_vec;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic hq[$];
    int   since   = 0;
    int   m_pend  = 0;
    int   m_total = 0;
    logic m_ovf   = 1'b0;
    logic m_pulse = 1'b0;
    logic m_level = 1'b0;
    logic m_armed = 1'b0;

    toggle_event_decoder #(
        .SYNC_STAGES(c_S),
        .PEND_W     (c_PW),
        .CNT_W      (c_CW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tog_in    (tog_in),
        .evt_ready (evt_ready),
        .clr_cnt   (clr_cnt),
        .level_out (level_out),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .pend_cnt  (pend_cnt),
        .total_cnt (total_cnt),
        .overflow  (overflow),
        .armed     (armed)
    );

    assign dut_vec = {level_out, evt_pulse, evt_valid, pend_cnt, total_cnt, overflow, armed};

    always #5 clk = ~clk;

    function automatic logic [16:0] exp_vec();
        return {m_level, m_pulse, m_pend != 0, 4'(m_pend), 8'(m_total), m_ovf, m_armed};
    endfunction

    // One clock edge: the model sees the inputs that were stable at the edge.
    // The line level seen at edge n is the tog_in sampled SYNC_STAGES edges
    // earlier; an event is a change of that delayed level once armed.
    task automatic tick();
        logic ev;
        logic acc;
        @(posedge clk);
        if (!rst_n) begin
            hq = {};
            repeat (c_S + 2) hq.push_back(1'b0);
            since   = 0;
            m_pend  = 0;
            m_total = 0;
            m_ovf   = 1'b0;
            m_pulse = 1'b0;
            m_level = 1'b0;
            m_armed = 1'b0;
        end else begin
            hq.push_back(tog_in);
            void'(hq.pop_front());
            since++;
            ev  = (since >= c_S + 2) && (hq[0] != hq[1]);
            acc = (m_pend != 0) && evt_ready;
            if (ev && !acc) begin
                if (m_pend == c_PMAX) m_ovf = 1'b1;
                else m_pend++;
            end else if (!ev && acc) begin
                m_pend--;
            end
            if (clr_cnt) begin
                m_total = 0;
                m_ovf   = 1'b0;
            end else if (ev) begin
                m_total = (m_total + 1) % c_CMOD;
            end
            m_pulse = ev;
            m_level = hq[1];
            m_armed = (since >= c_S + 1);
        end
        #1;
    endtask

    task automatic test_reset();
        tog_in = 1'b1; rst_n = 1'b0; evt_ready = 1'b0; clr_cnt = 1'b0;
        tick(); tick();
        checks++;
        if (dut_vec !== 17'h0) $display("FAIL reset_state: got %h want %h", dut_vec, 17'h0);
        else passes++;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL reset_model cyc%0d: got %h want %h", i, dut_vec, exp_vec());
            else passes++;
            checks++;
            if (armed !== (i >= 2)) $display("FAIL reset_armed cyc%0d: got %b want %b", i, armed, i >= 2);
            else passes++;
        end
        checks++;
        if ({level_out, evt_pulse, pend_cnt, total_cnt, overflow} !== {1'b1, 1'b0, 4'd0, 8'd0, 1'b0})
            $display("FAIL reset_release: lvl=%b pulse=%b pend=%0d tot=%0d ovf=%b want 1 0 0 0 0",
                     level_out, evt_pulse, pend_cnt, total_cnt, overflow);
        else passes++;
    endtask

    task automatic test_single_event();
        int pulses = 0;
        int valids = 0;
        int pulse_at = -1;
        evt_ready = 1'b1;
        tog_in = ~tog_in;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL single_model cyc%0d: got %h want %h", i, dut_vec, exp_vec());
            else passes++;
            if (evt_pulse === 1'b1) begin pulses++; pulse_at = i; end
            if (evt_valid === 1'b1) valids++;
        end
        checks++;
        if (pulses != 1 || pulse_at != c_S) $display("FAIL single_pulse: got %0d pulses at %0d want 1 at %0d", pulses, pulse_at, c_S);
        else passes++;
        checks++;
        if (valids != 1 || total_cnt !== 8'd1 || pend_cnt !== 4'd0)
            $display("FAIL single_counts: valid_cycles=%0d tot=%0d pend=%0d want 1 1 0", valids, total_cnt, pend_cnt);
        else passes++;
    endtask

    task automatic test_overflow();
        int accepts = 0;
        evt_ready = 1'b0; clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tog_in = ~tog_in;
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if (dut_vec !== exp_vec()) $display("FAIL ovf_model ev%0d: got %h want %h", k, dut_vec, exp_vec());
                else passes++;
            end
        end
        repeat (4) tick();
        checks++;
        if (pend_cnt !== 4'd15 || overflow !== 1'b1 || total_cnt !== 8'd20)
            $display("FAIL ovf_full: pend=%0d ovf=%b tot=%0d want 15 1 20", pend_cnt, overflow, total_cnt);
        else passes++;
        evt_ready = 1'b1;
        for (int i = 0; i < 40 && evt_valid === 1'b1; i++) begin
            accepts++;
            tick();
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL ovf_drain cyc%0d: got %h want %h", i, dut_vec, exp_vec());
            else passes++;
        end
        checks++;
        if (accepts != 15 || evt_valid !== 1'b0 || overflow !== 1'b1)
            $display("FAIL ovf_accepts: got %0d valid=%b ovf=%b want 15 0 1", accepts, evt_valid, overflow);
        else passes++;
        evt_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        evt_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tog_in = ~tog_in;
            repeat (4) tick();
        end
        checks++;
        if (pend_cnt !== 4'd3) $display("FAIL b2b_setup: pend got %0d want 3", pend_cnt);
        else passes++;
        tog_in = ~tog_in;
        tick(); tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        checks++;
        if (evt_pulse !== 1'b1 || pend_cnt !== 4'd3 || dut_vec !== exp_vec())
            $display("FAIL b2b_accept: pulse=%b pend=%0d want 1 3 (vec %h want %h)", evt_pulse, pend_cnt, dut_vec, exp_vec());
        else passes++;
        repeat (3) tick();
        tog_in = ~tog_in;
        tick(); tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (total_cnt !== 8'd0 || pend_cnt !== 4'd4 || evt_pulse !== 1'b1 || overflow !== 1'b0)
            $display("FAIL b2b_clear: tot=%0d pend=%0d pulse=%b ovf=%b want 0 4 1 0", total_cnt, pend_cnt, evt_pulse, overflow);
        else passes++;
        checks++;
        if (dut_vec !== exp_vec()) $display("FAIL b2b_model: got %h want %h", dut_vec, exp_vec());
        else passes++;
    endtask

    task automatic test_wrap();
        int max_seen = 0;
        evt_ready = 1'b1; clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        for (int k = 0; k < 256; k++) begin
            tog_in = ~tog_in;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (int'(total_cnt) > max_seen) max_seen = int'(total_cnt);
                checks++;
                if (dut_vec !== exp_vec()) $display("FAIL wrap_model ev%0d: got %h want %h", k, dut_vec, exp_vec());
                else passes++;
            end
        end
        repeat (4) tick();
        checks++;
        if (total_cnt !== 8'd0 || overflow !== 1'b0 || pend_cnt !== 4'd0 || max_seen != 255)
            $display("FAIL wrap_end: tot=%0d ovf=%b pend=%0d max=%0d want 0 0 0 255", total_cnt, overflow, pend_cnt, max_seen);
        else passes++;
    endtask

    task automatic test_random();
        int cyc = 0;
        int thr;
        while (cyc < 1500) begin
            thr = (cyc / 300) % 2 == 0 ? 1 : 6;
            tog_in = ~tog_in;
            for (int h = $urandom_range(3, 6); h > 0; h--) begin
                evt_ready = ($urandom_range(0, 7) < thr);
                clr_cnt   = ($urandom_range(0, 31) == 0);
                tick();
                cyc++;
                checks++;
                if (dut_vec !== exp_vec()) $display("FAIL random cyc%0d: got %h want %h", cyc, dut_vec, exp_vec());
                else passes++;
            end
        end
        evt_ready = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic test_reset_midop();
        int pulses = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        for (int k = 0; k < 7; k++) begin
            tog_in = ~tog_in;
            repeat (4) tick();
        end
        checks++;
        if (pend_cnt !== 4'd7) $display("FAIL midrst_setup: pend got %0d want 7", pend_cnt);
        else passes++;
        rst_n = 1'b0;
        tick();
        checks++;
        if (dut_vec !== 17'h0) $display("FAIL midrst_zero: got %h want %h", dut_vec, 17'h0);
        else passes++;
        rst_n = 1'b1;
        tog_in = ~tog_in;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (evt_pulse === 1'b1) pulses++;
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL midrst_model cyc%0d: got %h want %h", i, dut_vec, exp_vec());
            else passes++;
        end
        checks++;
        if (pulses != 0 || armed !== 1'b1 || pend_cnt !== 4'd0)
            $display("FAIL midrst_arm: pulses=%0d armed=%b pend=%0d want 0 1 0", pulses, armed, pend_cnt);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_overflow();
        test_back_to_back();
        test_wrap();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
